fetch_queue: RTL and testbench

Parametrised instruction-fetch front end with a prefetch FIFO, replacing the fixed single-register fetch path ahead of the IF/ID buffer. Owns the program counter, issues one read per cycle to the synchronous instruction memory (fixed 1-cycle read latency), and buffers returned instructions with their PC+increment. Decode consumes through a valid/ready handshake, so a hazard stall backpressures the queue instead of freezing the PC. A taken branch or jump from decode redirects the PC, flushes the queue and squashes the in-flight read.

---
 rtl/fetch_queue.sv | 113 +++++++++++
 tb/tb_fetch_queue.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the PC, issues one read per cycle to a 1-cycle
// synchronous instruction memory, and buffers responses in a small prefetch FIFO.
module fetch_queue #(
  parameter int PC_W     = 8,
  parameter int INSTR_W  = 16,
  parameter int DEPTH    = 4,
  parameter int PC_INC   = 2,
  parameter int RESET_PC = 0,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  output logic [PC_W-1:0]    imem_addr,
  output logic               imem_req,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc_next,
  input  logic               out_ready,
  output logic [CNT_W-1:0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PC_W-1:0] INC      = PC_W'(PC_INC);
  localparam logic [PC_W-1:0] START_PC = PC_W'(RESET_PC);

  logic [PC_W-1:0]    fetchPcReg, fetchPcNext;
  logic               inflightReg, inflightNext;
  logic [PC_W-1:0]    inflightPcReg, inflightPcNext;
  logic [PTR_W-1:0]   rdPtrReg, rdPtrNext;
  logic [PTR_W-1:0]   wrPtrReg, wrPtrNext;
  logic [CNT_W-1:0]   countReg, countNext;
  logic [INSTR_W-1:0] instrMem [DEPTH];
  logic [PC_W-1:0]    pcNextMem [DEPTH];

  logic               issue;
  logic               push;
  logic               pop;
  logic [CNT_W:0]     reserved;

  // Slots already owned by buffered entries plus the read in flight; a same-cycle
  // pop is deliberately not credited so the issue path stays off the ready input.
  assign reserved  = {1'b0, countReg} + {{CNT_W{1'b0}}, inflightReg};
  assign issue     = !rst && (redirect || (reserved < (CNT_W + 1)'(DEPTH)));
  assign imem_req  = issue;
  assign imem_addr = (redirect && !rst) ? redirect_pc : fetchPcReg;

  assign push        = inflightReg && !redirect;
  assign out_valid   = (countReg != '0);
  assign pop         = out_valid && out_ready;
  assign out_instr   = instrMem[rdPtrReg];
  assign out_pc_next = pcNextMem[rdPtrReg];
  assign count       = countReg;

  always_comb begin
    fetchPcNext    = fetchPcReg;
    inflightNext   = inflightReg;
    inflightPcNext = inflightPcReg;
    rdPtrNext      = rdPtrReg;
    wrPtrNext      = wrPtrReg;
    countNext      = countReg;
    if (redirect) begin
      fetchPcNext    = redirect_pc + INC;
      inflightNext   = 1'b1;
      inflightPcNext = redirect_pc;
      rdPtrNext      = '0;
      wrPtrNext      = '0;
      countNext      = '0;
    end else begin
      if (issue) begin
        fetchPcNext    = fetchPcReg + INC;
        inflightNext   = 1'b1;
        inflightPcNext = fetchPcReg;
      end else begin
        inflightNext = 1'b0;
      end
      if (push) wrPtrNext = wrPtrReg + PTR_W'(1);
      if (pop)  rdPtrNext = rdPtrReg + PTR_W'(1);
      case ({push, pop})
        2'b10:   countNext = countReg + CNT_W'(1);
        2'b01:   countNext = countReg - CNT_W'(1);
        default: countNext = countReg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetchPcReg    <= START_PC;
      inflightReg   <= 1'b0;
      inflightPcReg <= START_PC;
      rdPtrReg      <= '0;
      wrPtrReg      <= '0;
      countReg      <= '0;
    end else begin
      fetchPcReg    <= fetchPcNext;
      inflightReg   <= inflightNext;
      inflightPcReg <= inflightPcNext;
      rdPtrReg      <= rdPtrNext;
      wrPtrReg      <= wrPtrNext;
      countReg      <= countNext;
    end
  end

  // Storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      instrMem[wrPtrReg]  <= imem_rdata;
      pcNextMem[wrPtrReg] <= inflightPcReg + INC;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: synchronous memory model holding 16'h1000 + addr/2, and a
// scoreboard of expected PCs rebuilt on every reset or redirect.
module tb_fetch_queue;
  localparam int PC_W = 8, INSTR_W = 16, DEPTH = 4, PC_INC = 2, RESET_PC = 0;

  logic               clk;
  logic               rst;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_req;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect;
  logic [PC_W-1:0]    redirect_pc;
  logic               out_valid;
  logic [INSTR_W-1:0] out_instr;
  logic [PC_W-1:0]    out_pc_next;
  logic               out_ready;
  logic [2:0]         count;

  int checks = 0;
  int passes = 0;
  int accepted = 0;
  logic [7:0] sbQueue [$];

  fetch_queue #(
    .PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .PC_INC(PC_INC), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc_next(out_pc_next),
    .out_ready(out_ready), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (imem_req) imem_rdata <= 16'h1000 + 16'(imem_addr >> 1);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
    $fatal;
  end

  function automatic logic [15:0] expInstr(input logic [7:0] pc);
    return 16'h1000 + 16'(pc >> 1);
  endfunction

  task automatic restartSb(input logic [7:0] startPc);
    logic [7:0] pc;
    pc = startPc;
    sbQueue.delete();
    for (int i = 0; i < 64; i++) begin
      sbQueue.push_back(pc);
      pc = pc + 8'd2;
    end
  endtask

  // Scores the handshake of the current cycle, then advances one clock.
  task automatic tick();
    logic [7:0] pc;
    logic [7:0] nxt;
    if (!rst && out_valid && out_ready) begin
      accepted++;
      checks++;
      if (sbQueue.size() == 0) begin
        $display("FAIL sb_extra: got instr %h pc_next %h, required no output", out_instr, out_pc_next);
      end else begin
        pc = sbQueue.pop_front();
        nxt = pc + 8'd2;
        if (out_instr !== expInstr(pc) || out_pc_next !== nxt)
          $display("FAIL sb_order: got instr %h pc_next %h, required instr %h pc_next %h",
                   out_instr, out_pc_next, expInstr(pc), nxt);
        else passes++;
      end
      $display("xfer instr=%h pc_next=%h", out_instr, out_pc_next);
    end
    if (rst) restartSb(8'(RESET_PC));
    else if (redirect) restartSb(redirect_pc);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect = 1'b0; redirect_pc = 8'h00; out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || count !== 3'd0)
      $display("FAIL reset_state: got valid %b count %0d, required valid 0 count 0", out_valid, count);
    else passes++;
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 8'(RESET_PC))
      $display("FAIL reset_req: got req %b addr %h, required req 0 addr %h", imem_req, imem_addr, 8'(RESET_PC));
    else passes++;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h00)
      $display("FAIL first_req: got req %b addr %h, required req 1 addr 00", imem_req, imem_addr);
    else passes++;
  endtask

  task automatic test_stream();
    int gaps;
    tick();
    checks++;
    if (out_valid !== 1'b0) $display("FAIL lat_t1: got valid %b, required 0", out_valid);
    else passes++;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_instr !== 16'h1000 || out_pc_next !== 8'h02)
      $display("FAIL lat_t2: got valid %b instr %h pc_next %h, required 1 1000 02", out_valid, out_instr, out_pc_next);
    else passes++;
    gaps = 0;
    repeat (12) begin
      tick();
      if (out_valid !== 1'b1) gaps++;
    end
    checks++;
    if (gaps != 0) $display("FAIL stream_gaps: got %0d bubbles, required 0", gaps);
    else passes++;
  endtask

  task automatic test_stall_fill();
    int base;
    out_ready = 1'b0;
    repeat (6) tick();
    checks++;
    if (count !== 3'd4 || imem_req !== 1'b0)
      $display("FAIL stall_full: got count %0d req %b, required count 4 req 0", count, imem_req);
    else passes++;
    checks++;
    if (out_valid !== 1'b1 || out_instr !== expInstr(sbQueue[0]))
      $display("FAIL stall_head: got valid %b instr %h, required 1 %h", out_valid, out_instr, expInstr(sbQueue[0]));
    else passes++;
    out_ready = 1'b1;
    base = accepted;
    repeat (12) tick();
    checks++;
    if (accepted - base != 12)
      $display("FAIL stall_release: got %0d transfers, required 12", accepted - base);
    else passes++;
  endtask

  task automatic test_redirect_inflight();
    redirect = 1'b1; redirect_pc = 8'h40;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h40)
      $display("FAIL redir_addr: got req %b addr %h, required 1 40", imem_req, imem_addr);
    else passes++;
    tick();
    redirect = 1'b0;
    checks++;
    if (out_valid !== 1'b0) $display("FAIL redir_bubble: got valid %b, required 0", out_valid);
    else passes++;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_instr !== 16'h1020 || out_pc_next !== 8'h42)
      $display("FAIL redir_target: got valid %b instr %h pc_next %h, required 1 1020 42", out_valid, out_instr, out_pc_next);
    else passes++;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_instr !== 16'h1021 || out_pc_next !== 8'h44)
      $display("FAIL redir_next: got valid %b instr %h pc_next %h, required 1 1021 44", out_valid, out_instr, out_pc_next);
    else passes++;
  endtask

  task automatic test_redirect_full();
    out_ready = 1'b0;
    repeat (6) tick();
    checks++;
    if (count !== 3'd4) $display("FAIL rfull_pre: got count %0d, required 4", count);
    else passes++;
    redirect = 1'b1; redirect_pc = 8'h10;
    tick();
    redirect = 1'b0;
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0)
      $display("FAIL rfull_clear: got count %0d valid %b, required 0 0", count, out_valid);
    else passes++;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_instr !== 16'h1008 || out_pc_next !== 8'h12)
      $display("FAIL rfull_target: got valid %b instr %h pc_next %h, required 1 1008 12", out_valid, out_instr, out_pc_next);
    else passes++;
    out_ready = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_pc_wrap();
    redirect = 1'b1; redirect_pc = 8'hFC;
    #1;
    checks++;
    if (imem_addr !== 8'hFC) $display("FAIL wrap_addr0: got %h, required FC", imem_addr);
    else passes++;
    tick();
    redirect = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'hFE)
      $display("FAIL wrap_addr1: got req %b addr %h, required 1 FE", imem_req, imem_addr);
    else passes++;
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h00)
      $display("FAIL wrap_addr2: got req %b addr %h, required 1 00", imem_req, imem_addr);
    else passes++;
    checks++;
    if (out_valid !== 1'b1 || out_instr !== 16'h107E || out_pc_next !== 8'hFE)
      $display("FAIL wrap_out0: got valid %b instr %h pc_next %h, required 1 107E FE", out_valid, out_instr, out_pc_next);
    else passes++;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_instr !== 16'h107F || out_pc_next !== 8'h00)
      $display("FAIL wrap_out1: got valid %b instr %h pc_next %h, required 1 107F 00", out_valid, out_instr, out_pc_next);
    else passes++;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_instr !== 16'h1000 || out_pc_next !== 8'h02)
      $display("FAIL wrap_out2: got valid %b instr %h pc_next %h, required 1 1000 02", out_valid, out_instr, out_pc_next);
    else passes++;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    tick();
    tick();
    checks++;
    if (count !== 3'd3) $display("FAIL rmid_pre: got count %0d, required 3", count);
    else passes++;
    rst = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0) $display("FAIL rmid_req: got req %b, required 0", imem_req);
    else passes++;
    tick();
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0)
      $display("FAIL rmid_clear: got count %0d valid %b, required 0 0", count, out_valid);
    else passes++;
    rst = 1'b0; out_ready = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'(RESET_PC))
      $display("FAIL rmid_restart: got req %b addr %h, required 1 %h", imem_req, imem_addr, 8'(RESET_PC));
    else passes++;
    tick();
    checks++;
    if (out_valid !== 1'b0) $display("FAIL rmid_stale: got valid %b instr %h, required 0", out_valid, out_instr);
    else passes++;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_instr !== 16'h1000 || out_pc_next !== 8'h02)
      $display("FAIL rmid_first: got valid %b instr %h pc_next %h, required 1 1000 02", out_valid, out_instr, out_pc_next);
    else passes++;
    repeat (4) tick();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall_fill();
    test_redirect_inflight();
    test_redirect_full();
    test_pc_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
